// File: rtl/delay_addr_gen_pkg.sv
// Shared types and defaults for the delay-line address generator.
package delay_addr_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int DEFAULT_ADDRESS_WIDTH = 9;

endpackage

// File: rtl/delay_addr_gen_addr_counter.sv
// Wrapping up-counter with synchronous clear and enable; next_o is the value
// the counter will hold after the coming edge, for registering derived values.
module addr_counter #(
   parameter int WIDTH = 9
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o,
   output logic [WIDTH-1:0] next_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Natural overflow of the adder gives the max -> 0 wrap.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      count_q <= count_d;
   end

   assign count_o = count_q;
   assign next_o  = count_d;

endmodule

// File: rtl/delay_addr_gen.sv
// Write/read address and strobe generator for a two-port delay-line RAM.
// Optional `wrap` output enabled by defining DELAY_ADDR_GEN_WRAP_PULSE_EN.
module delay_addr_gen
   import delay_addr_gen_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clear,
   input  logic [ADDRESS_WIDTH-1:0] offset,
   output logic [ADDRESS_WIDTH-1:0] wr_addr,
   output logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic                     wr_en,
   output logic                     rd_en,
   output logic                     rd_valid,
   output logic                     filling,
`ifdef DELAY_ADDR_GEN_WRAP_PULSE_EN
   output logic                     wrap,
`endif
   output state_t                   state_dbg
);

   localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

   state_t                   state_q;
   logic [ADDRESS_WIDTH-1:0] offset_q;
   logic [ADDRESS_WIDTH-1:0] offset_d;
   logic [ADDRESS_WIDTH-1:0] fill_cnt_q;
   logic [ADDRESS_WIDTH-1:0] rd_addr_q;
   logic [ADDRESS_WIDTH-1:0] wr_ptr;
   logic [ADDRESS_WIDTH-1:0] wr_ptr_next;
   logic                     wr_en_q;
   logic                     rd_en_q;
   logic                     rd_valid_q;
   logic                     filling_q;
   logic                     restart;
   logic                     advance;

   assign restart = rst | clear;
   // The IDLE-exit write lands on address 0, so the pointer only moves afterwards.
   assign advance = en & (state_q != IDLE);

   addr_counter #(
      .WIDTH(ADDRESS_WIDTH)
   ) u_wr_ptr (
      .clk_i  (clk),
      .clr_i  (restart),
      .en_i   (advance),
      .count_o(wr_ptr),
      .next_o (wr_ptr_next)
   );

   always_comb begin
      offset_d = offset_q;
      if (state_q == IDLE && en) begin
         offset_d = offset;
      end
   end

   always_ff @(posedge clk) begin
      if (restart) begin
         state_q    <= IDLE;
         offset_q   <= '0;
         fill_cnt_q <= '0;
         rd_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         filling_q  <= 1'b0;
      end else begin
         wr_en_q    <= en;
         rd_en_q    <= 1'b0;
         rd_valid_q <= rd_en_q;
         rd_addr_q  <= wr_ptr_next - offset_d;
         case (state_q)
            IDLE: begin
               if (en) begin
                  offset_q   <= offset;
                  fill_cnt_q <= '0;
                  if (offset == '0) begin
                     state_q   <= RUN;
                     rd_en_q   <= 1'b1;
                     filling_q <= 1'b0;
                  end else begin
                     state_q   <= FILL;
                     filling_q <= 1'b1;
                  end
               end
            end
            FILL: begin
               // Reads start with the write that follows offset_q fill writes.
               if (en) begin
                  if (fill_cnt_q == offset_q - ONE) begin
                     state_q   <= RUN;
                     rd_en_q   <= 1'b1;
                     filling_q <= 1'b0;
                  end else begin
                     fill_cnt_q <= fill_cnt_q + ONE;
                  end
               end
            end
            RUN: begin
               rd_en_q <= en;
            end
            default: begin
               state_q   <= IDLE;
               filling_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef DELAY_ADDR_GEN_WRAP_PULSE_EN
   logic wrap_q;

   always_ff @(posedge clk) begin
      if (restart) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= advance & (wr_ptr == '1);
      end
   end

   assign wrap = wrap_q;
`endif

   assign wr_addr   = wr_ptr;
   assign rd_addr   = rd_addr_q;
   assign wr_en     = wr_en_q;
   assign rd_en     = rd_en_q;
   assign rd_valid  = rd_valid_q;
   assign filling   = filling_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_delay_addr_gen.sv
// Directed bench for delay_addr_gen with a write-count reference model and
// an expected-output queue checked one cycle after each drive.
module tb_delay_addr_gen;
   import delay_addr_gen_pkg::*;

   localparam int AW    = 9;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          clear;
   logic [AW-1:0] offset;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          wr_en;
   logic          rd_en;
   logic          rd_valid;
   logic          filling;
`ifdef DELAY_ADDR_GEN_WRAP_PULSE_EN
   logic          wrap;
`endif
   state_t        state_dbg;

   delay_addr_gen #(.ADDRESS_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clear    (clear),
      .offset   (offset),
      .wr_addr  (wr_addr),
      .rd_addr  (rd_addr),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .rd_valid (rd_valid),
      .filling  (filling),
`ifdef DELAY_ADDR_GEN_WRAP_PULSE_EN
      .wrap     (wrap),
`endif
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // {state[1:0], filling, rd_valid, rd_en, wr_en, rd_addr[8:0], wr_addr[8:0]}
   logic [23:0] exp_q[$];

   // Reference model: counts writes since the last start, no FSM.
   bit m_active = 0;
   int m_off    = 0;
   int m_wcnt   = 0;
   int m_waddr  = 0;
   bit m_wr_en  = 0;
   bit m_rd_en  = 0;
   bit m_rd_vld = 0;
   bit m_fill   = 0;
`ifdef DELAY_ADDR_GEN_WRAP_PULSE_EN
   bit m_wrap   = 0;
   bit wrap_q[$];
`endif

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      assert (act === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic c, input logic e, input logic [AW-1:0] o);
      logic [23:0]   exp;
      logic [1:0]    s;
      logic [AW-1:0] rd_exp;
      int            k;
      rst = r; clear = c; en = e; offset = o;
`ifdef DELAY_ADDR_GEN_WRAP_PULSE_EN
      m_wrap = 0;
`endif
      if (r || c) begin
         m_active = 0; m_off = 0; m_wcnt = 0; m_waddr = 0;
         m_wr_en = 0; m_rd_en = 0; m_rd_vld = 0; m_fill = 0;
      end else begin
         m_rd_vld = m_rd_en;
         if (!e) begin
            m_wr_en = 0;
            m_rd_en = 0;
         end else begin
            if (!m_active) begin
               m_active = 1;
               m_off    = int'(o);
               m_wcnt   = 0;
            end
            k = m_wcnt;
            m_wcnt++;
`ifdef DELAY_ADDR_GEN_WRAP_PULSE_EN
            m_wrap = (k > 0) && (k % DEPTH == 0);
`endif
            m_waddr = k % DEPTH;
            m_wr_en = 1;
            m_rd_en = (k >= m_off);
            m_fill  = (k < m_off);
         end
      end
      rd_exp = AW'(((m_waddr - m_off) % DEPTH + DEPTH) % DEPTH);
      s = !m_active ? IDLE : (m_fill ? FILL : RUN);
      exp_q.push_back({s, m_fill, m_rd_vld, m_rd_en, m_wr_en, rd_exp, AW'(m_waddr)});
`ifdef DELAY_ADDR_GEN_WRAP_PULSE_EN
      wrap_q.push_back(m_wrap);
`endif
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         tests++;
         failed++;
         $error("FAIL scoreboard: observed empty queue expected one entry");
      end else begin
         exp = exp_q.pop_front();
         check("wr_addr",  32'(wr_addr),   32'(exp[8:0]));
         check("rd_addr",  32'(rd_addr),   32'(exp[17:9]));
         check("wr_en",    32'(wr_en),     32'(exp[18]));
         check("rd_en",    32'(rd_en),     32'(exp[19]));
         check("rd_valid", 32'(rd_valid),  32'(exp[20]));
         check("filling",  32'(filling),   32'(exp[21]));
         check("state",    32'(state_dbg), 32'(exp[23:22]));
`ifdef DELAY_ADDR_GEN_WRAP_PULSE_EN
         check("wrap",     32'(wrap),      32'(wrap_q.pop_front()));
`endif
      end
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; en = 1'b0; offset = '0;

      // Reset, then idle with en low.
      repeat (2) step(1, 0, 0, 9'd0);
      repeat (10) step(0, 0, 0, 9'd0);

      // Fill with offset 3, then run.
      repeat (20) step(0, 0, 1, 9'd3);

      // Pause in RUN with a new offset that must be ignored.
      repeat (4) step(0, 0, 0, 9'd7);
      for (int i = 0; i < 200 && m_waddr != 100; i++) step(0, 0, 1, 9'd7);

      // Clear mid-run with en high: clear wins.
      step(0, 1, 1, 9'd2);
      repeat (8) step(0, 0, 1, 9'd2);

      // Zero offset: reads alongside writes from the first sample.
      step(0, 1, 0, 9'd0);
      repeat (8) step(0, 0, 1, 9'd0);

      // Pause during FILL keeps filling high.
      step(0, 1, 0, 9'd0);
      repeat (2) step(0, 0, 1, 9'd4);
      repeat (3) step(0, 0, 0, 9'd4);
      repeat (5) step(0, 0, 1, 9'd4);

      // Wrap with offset 5.
      step(0, 1, 0, 9'd0);
      repeat (600) step(0, 0, 1, 9'd5);

      // Maximum delay: rd_addr = wr_addr + 1.
      step(0, 1, 0, 9'd0);
      for (int i = 0; i < 515; i++) step(0, 0, ($urandom_range(0, 7) != 0), 9'd511);

      // Reset mid-run with clear and en also high.
      step(1, 1, 1, 9'd1);
      repeat (3) step(0, 0, 0, 9'd1);
      repeat (4) step(0, 0, 1, 9'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
